// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC owner and small {pc, instr} FIFO feeding decode; optional FETCH_OOB_HALT_EN halts fetch past the ROM
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter int          MEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [63:0]              imem_addr,
    input  logic [31:0]              imem_instr,
    input  logic                     stall,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [63:0]              out_pc,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [63:0]   pc;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] cnt;
    logic [0:0]    state;

    logic [31:0]   instr_q [DEPTH];
    logic [63:0]   pc_q    [DEPTH];

    logic        deq;
    logic        enq;
    logic        full;
    logic        oob;
    logic [63:0] redir_target;

    assign redir_target = redirect_pc & ~64'd3;

`ifdef FETCH_OOB_HALT_EN
    assign oob = (pc + 64'd3) >= 64'(MEM_BYTES);
`else
    assign oob = 1'b0;
`endif

    assign out_valid = (cnt != '0);
    assign deq       = out_valid & out_ready;
    assign full      = (cnt == CW'(DEPTH));
    assign enq       = (state == RUN) & ~stall & ~redirect_valid & ~oob & (~full | deq);

    assign imem_addr = pc;
    assign count     = cnt;
    assign halted    = (state == HALT);

    // Head entry is gated so the outputs read zero whenever the queue is empty.
    assign out_instr = out_valid ? instr_q[head] : 32'h0;
    assign out_pc    = out_valid ? pc_q[head]    : 64'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            state <= RUN;
        end else if (redirect_valid) begin
            pc    <= redir_target;
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            state <= RUN;
        end else begin
            if (enq) begin
                pc   <= pc + 64'd4;
                tail <= tail + AW'(1);
            end
            if (deq) begin
                head <= head + AW'(1);
            end
            cnt <= cnt + CW'(enq) - CW'(deq);
            // oob is tied low unless the halt feature is built in.
            if (state == RUN && oob) begin
                state <= HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            instr_q[tail] <= imem_instr;
            pc_q[tail]    <= pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue (FETCH_OOB_HALT_EN selects halt expectations)
module tb_fetch_queue;
    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready;
    logic [2:0]  count;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q [$];
    logic [63:0] fpc;

    fetch_queue #(.DEPTH(4), .MEM_BYTES(1024), .RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .count(count), .halted(halted)
    );

    function automatic logic [31:0] rom(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign imem_instr = rom(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs set; checks current state, predicts the coming edge, advances one cycle.
    task automatic tick(input bit exp_enq);
        logic [63:0] e;
        check("imem_addr", imem_addr, fpc);
        check("count", {61'h0, count}, 64'(exp_q.size()));
        check("out_valid", {63'h0, out_valid}, {63'h0, exp_q.size() != 0});
        if (out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                check("sb_nonempty", 64'h0, 64'h1);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e);
                check("out_instr", {32'h0, out_instr}, {32'h0, rom(e)});
            end
        end
        if (redirect_valid) begin
            exp_q.delete();
            fpc = {redirect_pc[63:2], 2'b00};
        end else if (exp_enq) begin
            exp_q.push_back(fpc);
            fpc = fpc + 64'd4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        out_ready = 1'b1;
        fpc = 64'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_count", {61'h0, count}, 64'h0);
        check("rst_imem_addr", imem_addr, 64'h0);
        check("rst_halted", {63'h0, halted}, 64'h0);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_out_instr", {32'h0, out_instr}, 64'h0);
        reset = 1'b0;

        // streaming: out_pc 0,4,8,12
        for (int i = 0; i < 4; i++) tick(1'b1);
        check("addr_leads_pc", imem_addr, out_pc + 64'd4);

        // fill to full with out_ready low, then simultaneous deq/enq while full
        redirect_valid = 1'b1; redirect_pc = 64'h0; out_ready = 1'b0;
        tick(1'b0);
        redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b1);
        tick(1'b0);
        check("full_addr_hold", imem_addr, 64'd16);
        out_ready = 1'b1;
        tick(1'b1);
        check("full_deq_enq_count", {61'h0, count}, 64'd4);

        // down to 3 entries, then redirect to 0x43
        stall = 1'b1;
        tick(1'b0);
        stall = 1'b0;
        check("pre_redirect_count", {61'h0, count}, 64'd3);
        redirect_valid = 1'b1; redirect_pc = 64'h43;
        tick(1'b0);
        redirect_valid = 1'b0;
        check("redir_count", {61'h0, count}, 64'd0);
        check("redir_addr", imem_addr, 64'h40);
        tick(1'b1);
        check("redir_out_pc", out_pc, 64'h40);

        // stall with 2 entries queued: drain, pc frozen
        out_ready = 1'b0;
        tick(1'b1);
        stall = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0);
        check("stall_drained", {61'h0, count}, 64'd0);
        check("stall_pc_frozen", imem_addr, 64'h48);
        stall = 1'b0;
        tick(1'b1);
        check("stall_resume_pc", out_pc, 64'h48);

        // fetch past the end of the ROM
        redirect_valid = 1'b1; redirect_pc = 64'd1020;
        tick(1'b0);
        redirect_valid = 1'b0;
        tick(1'b1);
        check("oob_entry_pc", out_pc, 64'd1020);
`ifdef FETCH_OOB_HALT_EN
        tick(1'b0);
        check("oob_halted", {63'h0, halted}, 64'h1);
        tick(1'b0);
        check("oob_halted_hold", {63'h0, halted}, 64'h1);
        check("oob_addr_hold", imem_addr, 64'd1024);
`else
        tick(1'b1);
        check("oob_no_halt", {63'h0, halted}, 64'h0);
        check("oob_entry_1024", out_pc, 64'd1024);
`endif
        redirect_valid = 1'b1; redirect_pc = 64'h0;
        tick(1'b0);
        redirect_valid = 1'b0;
        check("unhalt", {63'h0, halted}, 64'h0);
        tick(1'b1);
        check("resume_out_pc", out_pc, 64'h0);

        // asynchronous reset mid-cycle with 2 entries queued
        out_ready = 1'b0;
        tick(1'b1);
        check("pre_areset_count", {61'h0, count}, 64'd2);
        #2 reset = 1'b1;
        #1;
        check("areset_out_valid", {63'h0, out_valid}, 64'h0);
        check("areset_count", {61'h0, count}, 64'h0);
        check("areset_addr", imem_addr, 64'h0);
        exp_q.delete();
        fpc = 64'h0;
        out_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick(1'b1);
        check("post_reset_out_pc", out_pc, 64'h0);
        tick(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
